// File: rtl/rib_arbiter_bus_if.sv
// RIB bus bundle: master-side request/response and slave-side select/data.
// The "slave" modport is the interconnect's view; the "master" modport is the
// surrounding system (masters plus slave read data) that drives it.
interface rib_arbiter_bus_if #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 6,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]        m_req_i;
  logic [NUM_MASTERS-1:0]        m_we_i;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i;
  logic [NUM_MASTERS-1:0]        m_gnt_o;
  logic [NUM_MASTERS-1:0]        m_rvalid_o;
  logic [NUM_MASTERS-1:0]        m_err_o;
  logic [NUM_MASTERS*DATA_W-1:0] m_rdata_o;
  logic [NUM_SLAVES-1:0]         s_req_o;
  logic [NUM_SLAVES-1:0]         s_we_o;
  logic [NUM_SLAVES*ADDR_W-1:0]  s_addr_o;
  logic [NUM_SLAVES*DATA_W-1:0]  s_wdata_o;
  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata_i;
  logic                          hold_flag_o;

  modport master (
    output m_req_i, m_we_i, m_addr_i, m_wdata_i, s_rdata_i,
    input  m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o,
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o, hold_flag_o
  );

  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i, s_rdata_i,
    output m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o, hold_flag_o
  );
endinterface

// File: rtl/rib_arbiter_bus.sv
// RIB interconnect: NUM_MASTERS masters share one transfer slot per cycle to
// NUM_SLAVES slaves. Combinational grant/decode, registered read response.
module rib_arbiter_bus #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 6,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = 4,
  parameter int ARB_MODE    = 0,
  parameter logic [NUM_MASTERS-1:0] HOLD_MASK = NUM_MASTERS'(4'b1101)
) (
  input  logic              clk,
  input  logic              rst_n,
  rib_arbiter_bus_if.slave  bus
);

  localparam int MW = $clog2(NUM_MASTERS);

  logic [MW-1:0]          rr_ptr;
  logic [MW-1:0]          gnt_idx;
  logic                   gnt_any;
  logic [NUM_MASTERS-1:0] gnt;

  logic [ADDR_W-1:0]      gnt_addr;
  logic [DATA_W-1:0]      gnt_wdata;
  logic                   gnt_we;
  logic [SEL_W-1:0]       sel;
  logic                   dec_ok;

  logic [NUM_SLAVES-1:0]        s_req;
  logic [NUM_SLAVES-1:0]        s_we;
  logic [NUM_SLAVES*ADDR_W-1:0] s_addr;
  logic [NUM_SLAVES*DATA_W-1:0] s_wdata;

  logic                   rsp_valid;
  logic                   rsp_err;
  logic [MW-1:0]          rsp_mst;
  logic [SEL_W-1:0]       rsp_slv;
  logic [DATA_W-1:0]      rsp_data;

  logic [NUM_MASTERS-1:0]        m_rvalid;
  logic [NUM_MASTERS-1:0]        m_err;
  logic [NUM_MASTERS*DATA_W-1:0] m_rdata;

  // Pick the winner: fixed mode scans from 0, round-robin scans from rr_ptr with wrap
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
      idx = off;
      if (ARB_MODE == 1) begin
        idx = off + 32'(rr_ptr);
      end
      if (idx >= NUM_MASTERS) begin
        idx = idx - NUM_MASTERS;
      end
      if (!gnt_any && bus.m_req_i[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[MW-1:0];
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  // Route the granted master's address, data and direction onto the shared slot
  always_comb begin
    gnt_addr  = '0;
    gnt_wdata = '0;
    gnt_we    = 1'b0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      if (gnt_any && gnt_idx == MW'(m)) begin
        gnt_addr  = bus.m_addr_i[m*ADDR_W +: ADDR_W];
        gnt_wdata = bus.m_wdata_i[m*DATA_W +: DATA_W];
        gnt_we    = bus.m_we_i[m];
      end
    end
  end

  assign sel    = gnt_addr[ADDR_W-1 -: SEL_W];
  assign dec_ok = gnt_any && (32'(sel) < NUM_SLAVES);

  // Drive only the decoded slave; every other slave sees all-zero signals
  always_comb begin
    s_req   = '0;
    s_we    = '0;
    s_addr  = '0;
    s_wdata = '0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      if (dec_ok && sel == SEL_W'(s)) begin
        s_req[s]                   = 1'b1;
        s_we[s]                    = gnt_we;
        s_addr[s*ADDR_W +: ADDR_W] = {{SEL_W{1'b0}}, gnt_addr[ADDR_W-SEL_W-1:0]};
        s_wdata[s*DATA_W +: DATA_W] = gnt_wdata;
      end
    end
  end

  // Round-robin pointer moves past the last granted master
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == MW'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Capture a response slot for granted reads and for any decode error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_mst   <= '0;
      rsp_slv   <= '0;
    end else if (gnt_any && (!gnt_we || !dec_ok)) begin
      rsp_valid <= 1'b1;
      rsp_err   <= !dec_ok;
      rsp_mst   <= gnt_idx;
      rsp_slv   <= sel;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

  // Select the responding slave's read data (bounded mux, sel may exceed NUM_SLAVES)
  always_comb begin
    rsp_data = '0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      if (rsp_slv == SEL_W'(s)) begin
        rsp_data = bus.s_rdata_i[s*DATA_W +: DATA_W];
      end
    end
  end

  // Steer the response to its master; other masters see zero data
  always_comb begin
    m_rvalid = '0;
    m_err    = '0;
    m_rdata  = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      if (rsp_valid && rsp_mst == MW'(m)) begin
        m_rvalid[m] = 1'b1;
        m_err[m]    = rsp_err;
        m_rdata[m*DATA_W +: DATA_W] = rsp_err ? '0 : rsp_data;
      end
    end
  end

  assign bus.m_gnt_o     = gnt;
  assign bus.m_rvalid_o  = m_rvalid;
  assign bus.m_err_o     = m_err;
  assign bus.m_rdata_o   = m_rdata;
  assign bus.s_req_o     = s_req;
  assign bus.s_we_o      = s_we;
  assign bus.s_addr_o    = s_addr;
  assign bus.s_wdata_o   = s_wdata;
  assign bus.hold_flag_o = |(bus.m_req_i & HOLD_MASK);

endmodule

// File: tb/tb_rib_arbiter_bus.sv
// Directed bench for rib_arbiter_bus: one fixed-priority and one round-robin
// instance share the same stimulus; each step checks the relevant instance.
module tb_rib_arbiter_bus;

  localparam int NM = 4;
  localparam int NS = 6;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NM-1:0]    m_req   = '0;
  logic [NM-1:0]    m_we    = '0;
  logic [NM*AW-1:0] m_addr  = '0;
  logic [NM*DW-1:0] m_wdata = '0;
  logic [NS*DW-1:0] s_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rib_arbiter_bus_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bf ();
  rib_arbiter_bus_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) br ();

  assign bf.m_req_i = m_req;   assign br.m_req_i = m_req;
  assign bf.m_we_i = m_we;     assign br.m_we_i = m_we;
  assign bf.m_addr_i = m_addr; assign br.m_addr_i = m_addr;
  assign bf.m_wdata_i = m_wdata; assign br.m_wdata_i = m_wdata;
  assign bf.s_rdata_i = s_rdata; assign br.s_rdata_i = s_rdata;

  rib_arbiter_bus #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
                    .SEL_W(4), .ARB_MODE(0), .HOLD_MASK(4'b1101))
    dut_fx (.clk(clk), .rst_n(rst_n), .bus(bf.slave));

  rib_arbiter_bus #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
                    .SEL_W(4), .ARB_MODE(1), .HOLD_MASK(4'b1101))
    dut_rr (.clk(clk), .rst_n(rst_n), .bus(br.slave));

  function automatic logic [31:0] rd(input int s);
    return 32'hC0DE_0000 + 32'(s);
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int k, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    m_req[k]            = req;
    m_we[k]             = we;
    m_addr[k*AW +: AW]  = addr;
    m_wdata[k*DW +: DW] = wdata;
  endtask

  task automatic clear_inputs();
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [255:0] e;
    for (int s = 0; s < NS; s++) s_rdata[s*DW +: DW] = rd(s);

    // Reset state: all outputs zero with no requests
    @(negedge clk); #1;
    chk("rst_gnt",    256'(bf.m_gnt_o),    '0);
    chk("rst_rvalid", 256'(bf.m_rvalid_o), '0);
    chk("rst_err",    256'(bf.m_err_o),    '0);
    chk("rst_rdata",  256'(bf.m_rdata_o),  '0);
    chk("rst_sreq",   256'(bf.s_req_o),    '0);
    chk("rst_saddr",  256'(bf.s_addr_o),   '0);
    chk("rst_hold",   256'(bf.hold_flag_o), '0);
    chk("rst_rr_rvalid", 256'(br.m_rvalid_o), '0);
    rst_n = 1'b1;

    // Fixed priority: masters 0 and 2 read 0x1000_0010 together
    @(negedge clk);
    set_m(0, 1'b1, 1'b0, 32'h1000_0010, '0);
    set_m(2, 1'b1, 1'b0, 32'h1000_0010, '0);
    #1;
    chk("fx_gnt_m0", 256'(bf.m_gnt_o), 256'(4'b0001));
    chk("fx_sreq",   256'(bf.s_req_o), 256'(6'b000010));
    chk("fx_swe",    256'(bf.s_we_o),  '0);
    e = '0; e[1*AW +: AW] = 32'h0000_0010;
    chk("fx_saddr",  256'(bf.s_addr_o), e);
    chk("fx_hold_m0m2", 256'(bf.hold_flag_o), 256'(1'b1));
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("fx_rvalid_m0", 256'(bf.m_rvalid_o), 256'(4'b0001));
    e = '0; e[0 +: DW] = rd(1);
    chk("fx_rdata_m0",  256'(bf.m_rdata_o), e);
    chk("fx_gnt_m2",    256'(bf.m_gnt_o), 256'(4'b0100));
    @(negedge clk);
    clear_inputs();
    #1;
    chk("fx_rvalid_m2", 256'(bf.m_rvalid_o), 256'(4'b0100));
    e = '0; e[2*DW +: DW] = rd(1);
    chk("fx_rdata_m2",  256'(bf.m_rdata_o), e);
    chk("fx_err_none",  256'(bf.m_err_o), '0);
    chk("fx_idle_gnt",  256'(bf.m_gnt_o), '0);

    // Round-robin: all four masters hold reads, master k targets slave k
    do_reset();
    for (int k = 0; k < NM; k++) set_m(k, 1'b1, 1'b0, (32'(k) << 28) | 32'h100, '0);
    #1;
    chk("rr_gnt_c1", 256'(br.m_gnt_o), 256'(4'b0001));
    chk("rr_rv_c1",  256'(br.m_rvalid_o), '0);
    @(negedge clk); #1;
    chk("rr_gnt_c2", 256'(br.m_gnt_o), 256'(4'b0010));
    chk("rr_rv_c2",  256'(br.m_rvalid_o), 256'(4'b0001));
    e = '0; e[0*DW +: DW] = rd(0);
    chk("rr_rd_c2",  256'(br.m_rdata_o), e);
    @(negedge clk); #1;
    chk("rr_gnt_c3", 256'(br.m_gnt_o), 256'(4'b0100));
    chk("rr_rv_c3",  256'(br.m_rvalid_o), 256'(4'b0010));
    e = '0; e[1*DW +: DW] = rd(1);
    chk("rr_rd_c3",  256'(br.m_rdata_o), e);
    @(negedge clk); #1;
    chk("rr_gnt_c4", 256'(br.m_gnt_o), 256'(4'b1000));
    chk("rr_rv_c4",  256'(br.m_rvalid_o), 256'(4'b0100));
    @(negedge clk); #1;
    chk("rr_gnt_wrap", 256'(br.m_gnt_o), 256'(4'b0001));
    chk("rr_rv_c5",  256'(br.m_rvalid_o), 256'(4'b1000));
    e = '0; e[3*DW +: DW] = rd(3);
    chk("rr_rd_c5",  256'(br.m_rdata_o), e);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("rr_rv_c6",  256'(br.m_rvalid_o), 256'(4'b0001));
    chk("rr_gnt_c6", 256'(br.m_gnt_o), '0);

    // Master 3 writes 0xDEAD_BEEF to 0x2000_0004
    @(negedge clk);
    set_m(3, 1'b1, 1'b1, 32'h2000_0004, 32'hDEAD_BEEF);
    #1;
    chk("wr_gnt",  256'(bf.m_gnt_o), 256'(4'b1000));
    chk("wr_sreq", 256'(bf.s_req_o), 256'(6'b000100));
    chk("wr_swe",  256'(bf.s_we_o),  256'(6'b000100));
    e = '0; e[2*AW +: AW] = 32'h0000_0004;
    chk("wr_saddr", 256'(bf.s_addr_o), e);
    e = '0; e[2*DW +: DW] = 32'hDEAD_BEEF;
    chk("wr_swdata", 256'(bf.s_wdata_o), e);
    chk("wr_hold_m3", 256'(bf.hold_flag_o), 256'(1'b1));
    @(negedge clk);
    clear_inputs();
    #1;
    chk("wr_no_rvalid", 256'(bf.m_rvalid_o), '0);

    // Last valid slave (sel 5) read by master 1
    set_m(1, 1'b1, 1'b0, 32'h5000_0020, '0);
    #1;
    chk("sel5_sreq", 256'(bf.s_req_o), 256'(6'b100000));
    e = '0; e[5*AW +: AW] = 32'h0000_0020;
    chk("sel5_saddr", 256'(bf.s_addr_o), e);
    @(negedge clk);
    clear_inputs();

    // Decode error: master 0 reads 0x7000_0000
    set_m(0, 1'b1, 1'b0, 32'h7000_0000, '0);
    #1;
    chk("sel5_rvalid", 256'(bf.m_rvalid_o), 256'(4'b0010));
    e = '0; e[1*DW +: DW] = rd(5);
    chk("sel5_rdata", 256'(bf.m_rdata_o), e);
    chk("de_gnt",  256'(bf.m_gnt_o), 256'(4'b0001));
    chk("de_sreq", 256'(bf.s_req_o), '0);
    @(negedge clk);
    clear_inputs();
    set_m(1, 1'b1, 1'b1, 32'hF000_0000, 32'h1234_5678);
    #1;
    chk("de_rvalid", 256'(bf.m_rvalid_o), 256'(4'b0001));
    chk("de_err",    256'(bf.m_err_o),    256'(4'b0001));
    chk("de_rdata",  256'(bf.m_rdata_o),  '0);
    chk("dew_sreq",  256'(bf.s_req_o),    '0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("dew_rvalid", 256'(bf.m_rvalid_o), 256'(4'b0010));
    chk("dew_err",    256'(bf.m_err_o),    256'(4'b0010));

    // Hold flag: master 1 is masked out, master 2 is not
    @(negedge clk);
    set_m(1, 1'b1, 1'b0, 32'h0000_0000, '0);
    #1;
    chk("hold_m1", 256'(bf.hold_flag_o), '0);
    set_m(2, 1'b1, 1'b0, 32'h0000_0000, '0);
    #1;
    chk("hold_m1m2", 256'(bf.hold_flag_o), 256'(1'b1));
    @(negedge clk);
    clear_inputs();

    // Reset mid-transfer on the round-robin instance
    do_reset();
    set_m(1, 1'b1, 1'b0, 32'h1000_0000, '0);
    #1;
    chk("mr_gnt_m1", 256'(br.m_gnt_o), 256'(4'b0010));
    @(negedge clk);
    clear_inputs();
    set_m(2, 1'b1, 1'b0, 32'h0000_0000, '0);
    #1;
    chk("mr_gnt_m2", 256'(br.m_gnt_o), 256'(4'b0100));
    chk("mr_rv_m1",  256'(br.m_rvalid_o), 256'(4'b0010));
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_async_drop", 256'(br.m_rvalid_o), '0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("mr_in_rst_rvalid", 256'(br.m_rvalid_o), '0);
    chk("mr_in_rst_gnt",    256'(br.m_gnt_o), '0);
    chk("mr_in_rst_sreq",   256'(br.s_req_o), '0);
    chk("mr_in_rst_rdata",  256'(br.m_rdata_o), '0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("mr_post_rvalid", 256'(br.m_rvalid_o), '0);
    for (int k = 0; k < NM; k++) set_m(k, 1'b1, 1'b0, 32'h0000_0000, '0);
    #1;
    chk("mr_ptr_zero", 256'(br.m_gnt_o), 256'(4'b0001));
    @(negedge clk);
    clear_inputs();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
